wb_cmd_master: RTL and testbench

Single-outstanding Wishbone B4 pipelined master. It takes one command at a time over a valid/ready request port and runs the matching Wishbone read or write. It returns read data or error status over a valid/ready response port. It is the initiator counterpart to the peripheral-side Wishbone responders (debug/test-status slaves), and is used by debug and test logic to reach the peripheral bus without the core.

---
 rtl/wb_cmd_master_pkg.sv | 27 ++
 rtl/wb_timeout_ctr.sv | 41 ++++
 rtl/wb_cmd_master.sv | 136 +++++++++++++
 tb/tb_wb_cmd_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the single-outstanding Wishbone command master:
// FSM state encoding, default timeout and the command/response records.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        timeout;
  } rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: expired is registered and high during the LIMIT-th
// enabled cycle after clr, and stays high until the next clr.
module wb_timeout_ctr #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LIMIT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // cnt_q counts completed enabled cycles, so comparing the next count
  // against LIMIT-1 flags the LIMIT-th cycle without a combinational path.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    expired_d = (cnt_d == CNT_W'(LIMIT - 1));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined master driven by a valid/ready
// command port, returning read data / error / timeout on a valid/ready response port.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   tmo_clr, tmo_en, tmo_expired;
  logic   term;
  rsp_t   term_rsp, tmo_rsp;

  wb_timeout_ctr #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .expired  (tmo_expired)
  );

  // err outranks ack; data is only returned for a clean read.
  always_comb begin
    term             = wb_ack_i || wb_err_i;
    term_rsp.dat     = (wb_ack_i && !wb_err_i && !cmd_q.we) ? wb_dat_i : 32'h0;
    term_rsp.err     = wb_err_i;
    term_rsp.timeout = 1'b0;
    tmo_rsp.dat      = 32'h0;
    tmo_rsp.err      = 1'b0;
    tmo_rsp.timeout  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d   = S_REQ;
          cmd_d.we  = cmd_we_i;
          cmd_d.adr = cmd_adr_i;
          cmd_d.dat = cmd_dat_i;
          cmd_d.sel = cmd_sel_i;
          tmo_clr   = 1'b1;
        end
      end
      S_REQ: begin
        tmo_en = 1'b1;
        // A stalled slave has not taken the request, so its ack/err is not ours.
        if (!wb_stall_i && term) begin
          state_d = S_RESP;
          rsp_d   = term_rsp;
        end else if (tmo_expired) begin
          state_d = S_RESP;
          rsp_d   = tmo_rsp;
        end else if (!wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_en = 1'b1;
        if (term) begin
          state_d = S_RESP;
          rsp_d   = term_rsp;
        end else if (tmo_expired) begin
          state_d = S_RESP;
          rsp_d   = tmo_rsp;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign wb_cyc_o      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign wb_stb_o      = (state_q == S_REQ);
  assign wb_we_o       = cmd_q.we;
  assign wb_adr_o      = cmd_q.adr;
  assign wb_dat_o      = cmd_q.dat;
  assign wb_sel_o      = cmd_q.sel;
  assign rsp_dat_o     = rsp_q.dat;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed and randomized checks of wb_cmd_master against a transaction-level
// model that predicts latency, bus occupancy and response from the slave script.
module tb_wb_cmd_master;

  localparam int T = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_stall_i    (wb_stall_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_dat_i      (wb_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 no answer. Slave stalls s cycles, then
  // terminates w cycles after taking the request (w=0: same cycle).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int s, input int w, input int kind,
                         input logic [31:0] rdata, input int hold);
    int          term_c, end_c, exp_stb, stb_cnt, cyc_cnt, rsp_c;
    logic        exp_to, exp_err, bus_ok;
    logic [31:0] exp_dat;

    term_c  = s + 1 + w;
    exp_to  = (kind == 3) || (term_c > T);
    end_c   = exp_to ? T : term_c;
    exp_stb = (s + 1 < end_c) ? s + 1 : end_c;
    exp_err = !exp_to && (kind == 1 || kind == 2);
    exp_dat = (!exp_to && kind == 0 && !we) ? rdata : 32'h0;

    @(negedge wb_clk_i);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    cmd_sel_i   = ~sel;

    stb_cnt = 0;
    cyc_cnt = 0;
    rsp_c   = -1;
    bus_ok  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid_o) begin
        rsp_c = c;
        break;
      end
      if (wb_cyc_o) cyc_cnt++;
      if (wb_stb_o) begin
        stb_cnt++;
        if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {we, adr, dat, sel}) bus_ok = 1'b0;
      end
      wb_stall_i = (c <= s);
      wb_ack_i   = (c == term_c) && (kind == 0 || kind == 2);
      wb_err_i   = (c == term_c) && (kind == 1 || kind == 2);
      wb_dat_i   = (c == term_c) ? rdata : $urandom;
      @(negedge wb_clk_i);
    end
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;

    chk("rsp_latency", 32'(rsp_c), 32'(end_c + 1));
    chk("cyc_cycles", 32'(cyc_cnt), 32'(end_c));
    chk("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    chk("bus_fields", 32'(bus_ok), 32'd1);
    chk("cyc_in_resp", 32'(wb_cyc_o), 32'd0);

    // Backpressure: fields must hold and new commands must be refused; a late
    // ack after timeout must be ignored.
    for (int h = 0; h < hold; h++) begin
      cmd_valid_i = 1'b1;
      wb_ack_i    = exp_to;
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("hold_dat", rsp_dat_o, exp_dat);
      @(negedge wb_clk_i);
    end
    wb_ack_i    = 1'b0;
    cmd_valid_i = 1'b0;
    chk("rsp_dat", rsp_dat_o, exp_dat);
    chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout_o), 32'(exp_to));
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    chk("post_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("adr_held", wb_adr_o, adr);
  endtask

  initial begin
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_wb_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_wb_adr", wb_adr_o, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
    chk("rst_rsp_dat", rsp_dat_o, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    run_txn(1'b1, 32'h8000_0000, 32'h0000_0001, 4'hF, 0, 1, 0, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h8000_0004, 32'h0, 4'hF, 3, 1, 0, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 32'h8000_0008, 32'h0, 4'hF, 0, 1, 2, 32'hCAFE_F00D, 1);
    run_txn(1'b0, 32'h8000_000C, 32'h0, 4'h3, 0, 0, 3, 32'h0, 2);

    // Stray termination while idle must not start anything.
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("stray_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("stray_cyc", 32'(wb_cyc_o), 32'd0);
    chk("stray_rsp_valid", 32'(rsp_valid_o), 32'd0);

    run_txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 1, 0, 32'hA5A5_5A5A, 5);
    run_txn(1'b0, 32'h8000_0014, 32'h0, 4'hC, 3, 4, 0, 32'h0BAD_CAFE, 0);
    run_txn(1'b0, 32'h8000_0018, 32'h0, 4'hF, 3, 5, 0, 32'h1111_2222, 0);
    run_txn(1'b1, 32'h8000_001C, 32'h55, 4'h1, 9, 0, 0, 32'h3333_4444, 0);
    run_txn(1'b0, 32'h8000_0020, 32'h0, 4'hF, 0, 0, 1, 32'h7777_8888, 0);
    run_txn(1'b0, 32'h8000_0024, 32'h0, 4'hF, 2, 0, 0, 32'h9999_AAAA, 0);

    // Reset while waiting for the slave.
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h8000_0100;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    @(negedge wb_clk_i);
    chk("wait_cyc", 32'(wb_cyc_o), 32'd1);
    chk("wait_stb", 32'(wb_stb_o), 32'd0);
    wb_rst_i = 1'b1;
    #1;
    chk("rst_async_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_async_stb", 32'(wb_stb_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_rel_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rel_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rel_adr", wb_adr_o, 32'd0);

    for (int i = 0; i < 24; i++) begin
      int r, k;
      r = $urandom_range(0, 4);
      k = (r < 2) ? 0 : r - 1;
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom_range(0, 5), k, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
